tri_edge_sequencer: RTL

Upstream stage for `bresenham_line_drawer`: accepts one triangle (three vertices) per valid/ready handshake and issues its three edges, one at a time, as start-pulsed line requests. For each edge it holds the endpoint coordinates stable until the drawer reports done, then moves to the next edge. It reports completion of the whole triangle to the wireframe front end.

---
 rtl/tri_edge_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/tri_edge_sequencer.sv
// tri_edge_sequencer: issues the three edges of a triangle to a line drawer, one start/done handshake per edge
//   clk, rst_n                  clock, asynchronous active-low reset
//   tri_valid/tri_ready         triangle handshake, vertices tri_x0..2 / tri_y0..2
//   ld_start                    one-cycle start pulse per issued edge
//   ld_x0/ld_y0 -> ld_x1/ld_y1  edge endpoints, held until ld_done
//   ld_done                     drawer completion pulse
//   busy, tri_done              triangle in flight, one-cycle completion pulse
//   TRI_EDGE_CULL_EN            when defined, edges lying wholly off-screen are skipped
module tri_edge_sequencer #(
  parameter int X_WIDTH  = 11,
  parameter int Y_WIDTH  = 11,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic [X_WIDTH-1:0] tri_x0,
  input  logic [X_WIDTH-1:0] tri_x1,
  input  logic [X_WIDTH-1:0] tri_x2,
  input  logic [Y_WIDTH-1:0] tri_y0,
  input  logic [Y_WIDTH-1:0] tri_y1,
  input  logic [Y_WIDTH-1:0] tri_y2,
  output logic               ld_start,
  output logic [X_WIDTH-1:0] ld_x0,
  output logic [X_WIDTH-1:0] ld_x1,
  output logic [Y_WIDTH-1:0] ld_y0,
  output logic [Y_WIDTH-1:0] ld_y1,
  input  logic               ld_done,
  output logic               busy,
  output logic               tri_done
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;
  logic [1:0] idx;
  logic [X_WIDTH-1:0] vx0, vx1, vx2, ex0, ex1;
  logic [Y_WIDTH-1:0] vy0, vy1, vy2, ey0, ey1;
  logic cull_n;
  // endpoints of the edge about to be issued: edge 0 straight from the inputs, later edges from the latched vertices
  always_comb begin
    ex0 = state == IDLE ? tri_x0 : idx == 2'd0 ? vx1 : vx2;
    ey0 = state == IDLE ? tri_y0 : idx == 2'd0 ? vy1 : vy2;
    ex1 = state == IDLE ? tri_x1 : idx == 2'd0 ? vx2 : vx0;
    ey1 = state == IDLE ? tri_y1 : idx == 2'd0 ? vy2 : vy0;
  end
`ifdef TRI_EDGE_CULL_EN
  assign cull_n = (ex0 >= X_WIDTH'(SCREEN_W) && ex1 >= X_WIDTH'(SCREEN_W)) ||
                  (ey0 >= Y_WIDTH'(SCREEN_H) && ey1 >= Y_WIDTH'(SCREEN_H));
`else
  logic unused_screen;
  assign cull_n = 1'b0;
  assign unused_screen = ^{SCREEN_W, SCREEN_H};
`endif
  // ld_start is loaded as !cull on entry to ISSUE, so a low ld_start in ISSUE marks a culled edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      {vx0, vx1, vx2, vy0, vy1, vy2} <= '0;
      {ld_x0, ld_y0, ld_x1, ld_y1}   <= '0;
      ld_start  <= 1'b0;
      tri_ready <= 1'b1;
      busy      <= 1'b0;
      tri_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tri_valid && tri_ready) begin
          {vx0, vx1, vx2, vy0, vy1, vy2} <= {tri_x0, tri_x1, tri_x2, tri_y0, tri_y1, tri_y2};
          {ld_x0, ld_y0, ld_x1, ld_y1}   <= {ex0, ey0, ex1, ey1};
          ld_start  <= !cull_n;
          idx       <= 2'd0;
          tri_ready <= 1'b0;
          busy      <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: if (ld_start) begin
          ld_start <= 1'b0;
          state    <= WAIT;
        end else if (idx == 2'd2) begin
          tri_done <= 1'b1;
          state    <= DONE;
        end else begin
          {ld_x0, ld_y0, ld_x1, ld_y1} <= {ex0, ey0, ex1, ey1};
          ld_start <= !cull_n;
          idx      <= idx + 2'd1;
        end
        WAIT: if (ld_done) begin
          if (idx == 2'd2) begin
            tri_done <= 1'b1;
            state    <= DONE;
          end else begin
            {ld_x0, ld_y0, ld_x1, ld_y1} <= {ex0, ey0, ex1, ey1};
            ld_start <= !cull_n;
            idx      <= idx + 2'd1;
            state    <= ISSUE;
          end
        end
        DONE: begin
          tri_done  <= 1'b0;
          tri_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
